led_pwm_driver: RTL
===================

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 Parameter PWM_BITS, default 8: width of PWM counter and per-channel duty registers.
REQ-002 Parameter STEP, default 16: duty increment or decrement applied per PWM period while fading.
REQ-003 Port clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port colour  input  3  colour code from the light controller; bit0 = red, bit1 = green, bit2 = blue.
REQ-006 Port enable  input  1  1 = drive LEDs; 0 = force all LED outputs low (state still advances).
REQ-007 Port led_r  output  1  red PWM drive.
REQ-008 Port led_g  output  1  green PWM drive.
REQ-009 Port led_b  output  1  blue PWM drive.
REQ-010 Port busy  output  1  high while any channel duty differs from its target.

Function
REQ-011 colour SHALL be registered into colour_q every cycle; targets derive from colour_q only (1-cycle input latency).
REQ-012 Per channel, target SHALL be MAX (2^PWM_BITS-1) when the corresponding colour_q bit is 1, else 0; all 8 codes valid (000 = off, 111 = white).
REQ-013 A free-running PWM_BITS-wide counter cnt SHALL increment every cycle and wrap MAX->0; period = 2^PWM_BITS cycles.
REQ-014 Channel output SHALL be 1 when duty == MAX, else (cnt < duty); ANDed with enable; outputs registered (1-cycle after cnt/duty).
REQ-015 Duty registers SHALL update only on the cycle where cnt == MAX, so a new duty takes effect from cnt == 0.
REQ-016 On update, duty < target: duty = min(duty + STEP, MAX); duty > target: duty = max(duty - STEP, 0); equal: unchanged; arithmetic in PWM_BITS+1 bits, no wrap-around.
REQ-017 FSM states IDLE and FADING; IDLE->FADING on the cycle any duty != its target; FADING->IDLE on the cycle all duties equal their targets.
REQ-018 busy SHALL be 1 exactly in state FADING.
REQ-019 A target change mid-fade SHALL redirect fading from the current duty toward the new target; no restart from 0 and no skipped period.
REQ-020 Channels fade independently; simultaneous rise on one channel and fall on another SHALL both step at the same period boundary.
REQ-021 colour changes shorter than one period SHALL affect only the target in effect at the next cnt == MAX.
REQ-022 enable SHALL not pause cnt, fading or busy; it gates outputs only, effective 1 cycle after change.

Reset
REQ-023 While rst = 1: cnt = 0, colour_q = 000, all duties = 0, FSM = IDLE, led_r/led_g/led_b = 0, busy = 0.
REQ-024 rst assertion SHALL clear state immediately (asynchronous), including mid-fade and mid-period.
REQ-025 After rst release, the first cnt == MAX boundary is 2^PWM_BITS cycles later.

Verification (PWM_BITS = 8, STEP = 64 unless noted)
REQ-026 Reset, colour = 001, enable = 1 -> busy rises 2 cycles after release; red duty 64, 128, 192, 255 at successive boundaries; busy falls after 4th; led_r then constant 1.
REQ-027 Steady red duty 128 (target held via colour 001 stopped mid-ramp by redirect) -> led_r high 128 of 256 cycles per period.
REQ-028 Red at 255, colour 001 -> 010 -> red 191, 127, 63, 0 and green 64, 128, 192, 255 on the same boundaries; busy high for 4 periods.
REQ-029 Red rising at duty 128, colour -> 000 -> next boundary duty 64, then 0; no value above 128 appears.
REQ-030 enable = 0 with colour 111 for 5 periods -> all LEDs 0 throughout, busy falls after 4 periods; enable = 1 -> all LEDs 1 next cycle.
REQ-031 rst pulse mid-fade at cnt = 100 -> outputs, busy, duties 0 asynchronously; fade restarts from 0 after release.

Source files
------------

// File: rtl/led_pwm_driver.sv
// Three-channel LED PWM driver. Each channel fades one STEP per PWM period
// toward full-on or full-off, as selected by the registered colour code.
module led_pwm_driver #(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] colour,
  input  logic       enable,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       busy
);

  localparam int NUM_CH = 3;
  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam logic [PWM_BITS:0]   MAX_W  = {1'b0, MAX};
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS + 1)'(STEP);

  typedef enum logic {
    IDLE,
    FADING
  } state_t;

  state_t state, state_next;

  logic [2:0]                       colour_q;
  logic [PWM_BITS-1:0]              cnt;
  logic                             period_end;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  duty;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  duty_next;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  target;
  logic [NUM_CH-1:0][PWM_BITS:0]    duty_up;
  logic [NUM_CH-1:0]                mismatch;
  logic [NUM_CH-1:0]                pwm;

  assign period_end = (cnt == MAX);

  // Per-channel target, saturating step and PWM comparison.
  // Arithmetic is one bit wider than the duty so neither direction can wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    target    = '0;
    duty_up   = '0;
    duty_next = duty;
    mismatch  = '0;
    pwm       = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      target[ch]   = colour_q[ch] ? MAX : '0;
      mismatch[ch] = (duty[ch] != target[ch]);
      duty_up[ch]  = {1'b0, duty[ch]} + STEP_W;
      if (duty[ch] < target[ch]) begin
        duty_next[ch] = (duty_up[ch] > MAX_W) ? MAX : duty_up[ch][PWM_BITS-1:0];
      end else if (duty[ch] > target[ch]) begin
        duty_next[ch] = ({1'b0, duty[ch]} < STEP_W) ? '0
                      : PWM_BITS'({1'b0, duty[ch]} - STEP_W);
      end
      pwm[ch] = (duty[ch] == MAX) || (cnt < duty[ch]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      cnt      <= '0;
      colour_q <= '0;
      duty     <= '0;
      led_r    <= 1'b0;
      led_g    <= 1'b0;
      led_b    <= 1'b0;
    end else begin
      cnt      <= cnt + PWM_BITS'(1);
      colour_q <= colour;
      if (period_end) begin
        duty <= duty_next;
      end
      // Enable only gates the drive; counter and fading keep running.
      led_r <= pwm[0] & enable;
      led_g <= pwm[1] & enable;
      led_b <= pwm[2] & enable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|mismatch)  state_next = FADING;
      FADING:  if (!(|mismatch)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == FADING);

endmodule
